// File: rtl/esc_ping_pkg.sv
// Shared types, defaults and round-robin index selection for the escalation ping scheduler.
// Combinational helpers only; no state and no flow control.
package esc_ping_pkg;

  localparam int NumEscDefault = 4;
  localparam int CntWDefault   = 16;
  localparam int MaxEsc        = 32;
  localparam int MaxEscW       = 5;

  typedef enum logic [1:0] {
    Idle,
    Wait,
    Ping
  } state_e;

  // First set bit of mask strictly after 'last', wrapping n-1 to 0; returns 'last' if mask is empty.
  function automatic logic [MaxEscW-1:0] rr_next(input logic [MaxEsc-1:0] mask,
                                                 input int               last,
                                                 input int               n);
    logic               found;
    logic [MaxEscW-1:0] cand;
    rr_next = MaxEscW'(last);
    found   = 1'b0;
    for (int k = 1; k <= MaxEsc; k++) begin
      cand = MaxEscW'((last + k) % n);
      if (k <= n && !found && mask[cand]) begin
        rr_next = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/esc_ping_sched.sv
// Round-robin ping scheduler: waits wait_cyc_i+1 cycles, then pings one sender for up to timeout_cyc_i+1 cycles.
// ping_en_o comes from registered state only; ping_fail_o pulses in the final window cycle when no ack arrives.
module esc_ping_sched
  import esc_ping_pkg::*;
#(
  parameter int NumEsc = NumEscDefault,
  parameter int CntW   = CntWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NumEsc-1:0] chan_en_i,
  input  logic [CntW-1:0]   wait_cyc_i,
  input  logic [CntW-1:0]   timeout_cyc_i,
  output logic [NumEsc-1:0] ping_en_o,
  input  logic [NumEsc-1:0] ping_ok_i,
  output logic [NumEsc-1:0] ping_fail_o
);

  localparam int IdxW = (NumEsc > 1) ? $clog2(NumEsc) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic              active;
  logic              ack;

  assign active = en_i && (|chan_en_i);
  assign ack    = ping_ok_i[idx_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IdxW'(NumEsc - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    last_d      = last_q;
    ping_fail_o = '0;
    unique case (state_q)
      Idle: begin
        if (active) begin
          state_d = Wait;
          cnt_d   = wait_cyc_i;
        end
      end
      Wait: begin
        if (!active) begin
          state_d = Idle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          idx_d   = IdxW'(rr_next(MaxEsc'(chan_en_i), int'(last_q), NumEsc));
          state_d = Ping;
          cnt_d   = timeout_cyc_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      Ping: begin
        // An abort outranks both ack and timeout: nothing is recorded and no pulse is raised.
        if (!active) begin
          state_d = Idle;
          cnt_d   = '0;
        end else if (ack) begin
          last_d  = idx_q;
          state_d = Wait;
          cnt_d   = wait_cyc_i;
        end else if (cnt_q == '0) begin
          ping_fail_o[idx_q] = 1'b1;
          last_d  = idx_q;
          state_d = Wait;
          cnt_d   = wait_cyc_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = Idle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ping_en_o = '0;
    for (int i = 0; i < NumEsc; i++) begin
      ping_en_o[i] = (state_q == Ping) && (idx_q == IdxW'(i));
    end
  end

endmodule

// File: tb/tb_esc_ping_sched.sv
// Randomized and directed bench for esc_ping_sched against a deadline-based behavioural model.
module tb_esc_ping_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [3:0]  chan_en_i;
  logic [15:0] wait_cyc_i;
  logic [15:0] timeout_cyc_i;
  logic [3:0]  ping_en_o;
  logic [3:0]  ping_ok_i;
  logic [3:0]  ping_fail_o;

  always #5 clk_i = ~clk_i;

  esc_ping_sched #(.NumEsc(4), .CntW(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .chan_en_i     (chan_en_i),
    .wait_cyc_i    (wait_cyc_i),
    .timeout_cyc_i (timeout_cyc_i),
    .ping_en_o     (ping_en_o),
    .ping_ok_i     (ping_ok_i),
    .ping_fail_o   (ping_fail_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 wait, 2 ping; m_end is the absolute cycle number of the phase's last cycle.
  int m_phase, m_end, m_idx, m_last, m_age, cyc = 0;
  logic [3:0] exp_en, exp_fail;

  function automatic logic [3:0] oh(input int i);
    oh = 4'b0001 << i;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = 3;
    m_idx   = 0;
    m_age   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni    = 1'b0;
    en_i      = 1'b0;
    ping_ok_i = 4'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  // Drives one cycle of inputs, predicts this cycle's outputs and advances the model.
  task automatic tick(input logic en, input logic [3:0] chan, input logic [15:0] wt,
                      input logic [15:0] to, input logic [3:0] ok);
    logic act;
    @(negedge clk_i);
    en_i = en; chan_en_i = chan; wait_cyc_i = wt; timeout_cyc_i = to; ping_ok_i = ok;
    #1;
    act      = en && (chan != 4'b0);
    exp_en   = (m_phase == 2) ? oh(m_idx) : 4'b0;
    exp_fail = (m_phase == 2 && act && !ok[m_idx] && cyc == m_end) ? oh(m_idx) : 4'b0;
    if (m_phase != 0 && !act) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (act) begin
        m_phase = 1;
        m_end   = cyc + 1 + int'(wt);
      end
    end else if (m_phase == 1) begin
      if (cyc == m_end) begin
        for (int k = 1; k <= 4; k++) begin
          if (chan[(m_last + k) % 4]) begin
            m_idx = (m_last + k) % 4;
            break;
          end
        end
        m_phase = 2;
        m_age   = 0;
        m_end   = cyc + 1 + int'(to);
      end
    end else begin
      if (ok[m_idx] || cyc == m_end) begin
        m_last  = m_idx;
        m_phase = 1;
        m_end   = cyc + 1 + int'(wt);
      end else begin
        m_age++;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1; en_i = 1'b0; chan_en_i = 4'b0; wait_cyc_i = '0; timeout_cyc_i = '0; ping_ok_i = 4'b0;
    #1 rst_ni = 1'b0;
    #2;
    checks++;
    if (ping_en_o !== 4'b0) begin
      errors++; $display("FAIL reset_ping_en got %b want 0000", ping_en_o);
    end
    checks++;
    if (ping_fail_o !== 4'b0) begin
      errors++; $display("FAIL reset_ping_fail got %b want 0000", ping_fail_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, 4'hF, 16'd3, 16'd5, (m_phase == 2 && m_age == 1) ? oh(m_idx) : 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL basic_en c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if (ping_fail_o !== exp_fail) begin errors++; $display("FAIL basic_fail c%0d got %b want %b", i, ping_fail_o, exp_fail); end
      if (i == 5) begin
        checks++;
        if (ping_en_o !== 4'b0001) begin errors++; $display("FAIL basic_first got %b want 0001", ping_en_o); end
      end
      if (i == 11) begin
        checks++;
        if (ping_en_o !== 4'b0010) begin errors++; $display("FAIL basic_second got %b want 0010", ping_en_o); end
      end
    end
  endtask

  task automatic test_timeout();
    int hi0 = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'hF, 16'd0, 16'd2, 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL timeout_en c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if (ping_fail_o !== exp_fail) begin errors++; $display("FAIL timeout_fail c%0d got %b want %b", i, ping_fail_o, exp_fail); end
      if (ping_en_o[0]) hi0++;
      if (i == 4) begin
        checks++;
        if (ping_fail_o !== 4'b0001) begin errors++; $display("FAIL timeout_pulse got %b want 0001", ping_fail_o); end
      end
      if (i == 6) begin
        checks++;
        if (ping_en_o !== 4'b0010) begin errors++; $display("FAIL timeout_next got %b want 0010", ping_en_o); end
      end
    end
    checks++;
    if (hi0 != 3) begin errors++; $display("FAIL timeout_len got %0d want 3", hi0); end
  endtask

  task automatic test_mask_skip();
    logic [3:0] seq[$];
    logic [3:0] want[4];
    logic [3:0] prev = 4'b0;
    want = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 4'b1010, 16'd1, 16'd1, (m_phase == 2) ? oh(m_idx) : 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL mask_en c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if ((ping_en_o & 4'b0101) !== 4'b0) begin errors++; $display("FAIL mask_masked c%0d got %b want bits0,2 clear", i, ping_en_o); end
      if (ping_en_o != 4'b0 && prev == 4'b0) seq.push_back(ping_en_o);
      prev = ping_en_o;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= seq.size()) begin
        errors++; $display("FAIL mask_seq%0d got none want %b", k, want[k]);
      end else if (seq[k] !== want[k]) begin
        errors++; $display("FAIL mask_seq%0d got %b want %b", k, seq[k], want[k]);
      end
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 4'hF, 16'd0, 16'd1, (m_phase == 2 && m_age == 1) ? oh(m_idx) : 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL tie_en c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if (ping_fail_o !== 4'b0) begin errors++; $display("FAIL tie_fail c%0d got %b want 0000", i, ping_fail_o); end
      if (i == 5) begin
        checks++;
        if (ping_en_o !== 4'b0010) begin errors++; $display("FAIL tie_advance got %b want 0010", ping_en_o); end
      end
    end
  endtask

  task automatic test_abort();
    logic en;
    logic prev_en = 1'b1;
    int   drop = 0;
    bit   aborted = 0;
    bit   seen = 0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      en = 1'b1;
      if (!aborted && m_phase == 2 && m_idx == 1 && m_age == 1) begin aborted = 1; drop = 2; end
      if (drop > 0) begin en = 1'b0; drop--; end
      tick(en, 4'hF, 16'd1, 16'd4, (m_phase == 2 && m_idx == 0) ? 4'b0001 : 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL abort_en c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if (ping_fail_o !== exp_fail) begin errors++; $display("FAIL abort_fail c%0d got %b want %b", i, ping_fail_o, exp_fail); end
      if (!en) begin
        checks++;
        if (ping_fail_o !== 4'b0) begin errors++; $display("FAIL abort_nopulse got %b want 0000", ping_fail_o); end
      end
      if (!prev_en) begin
        checks++;
        if (ping_en_o !== 4'b0) begin errors++; $display("FAIL abort_drop got %b want 0000", ping_en_o); end
      end
      if (aborted && drop == 0 && en && !seen && ping_en_o != 4'b0) begin
        seen = 1;
        checks++;
        if (ping_en_o !== 4'b0010) begin errors++; $display("FAIL abort_resume got %b want 0010", ping_en_o); end
      end
      prev_en = en;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_resume got no ping want 0010"); end
  endtask

  task automatic test_reset_mid_ping();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 4'hF, 16'd2, 16'd6, 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL rstmid_pre c%0d got %b want %b", i, ping_en_o, exp_en); end
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (ping_en_o !== 4'b0) begin errors++; $display("FAIL rstmid_en got %b want 0000", ping_en_o); end
    checks++;
    if (ping_fail_o !== 4'b0) begin errors++; $display("FAIL rstmid_fail got %b want 0000", ping_fail_o); end
    @(negedge clk_i);
    en_i   = 1'b0;
    rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'hF, 16'd2, 16'd6, 4'b0);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL rstmid_post c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if (ping_fail_o !== exp_fail) begin errors++; $display("FAIL rstmid_pfail c%0d got %b want %b", i, ping_fail_o, exp_fail); end
      if (i == 4) begin
        checks++;
        if (ping_en_o !== 4'b0001) begin errors++; $display("FAIL rstmid_first got %b want 0001", ping_en_o); end
      end
    end
  endtask

  task automatic test_random();
    logic        en;
    logic [3:0]  chan, ok;
    logic [15:0] wt, to;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      chan = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
      wt   = 16'($urandom_range(0, 3));
      to   = 16'($urandom_range(0, 3));
      ok   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      tick(en, chan, wt, to, ok);
      checks++;
      if (ping_en_o !== exp_en) begin errors++; $display("FAIL rand_en c%0d got %b want %b", i, ping_en_o, exp_en); end
      checks++;
      if (ping_fail_o !== exp_fail) begin errors++; $display("FAIL rand_fail c%0d got %b want %b", i, ping_fail_o, exp_fail); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_mask_skip();
    test_tie();
    test_abort();
    test_reset_mid_ping();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
